// File: rtl/fp_add_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | fp_add_sched_pkg : shared types and helpers for the FP32 adder scheduler |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package fp_add_sched_pkg;

  localparam int FP_W        = 32;
  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADD_LAT = 3;
  // Tag ID is sized for the largest supported requester count (8).
  localparam int TAG_IDW     = 3;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  function automatic logic [TAG_IDW-1:0] rr_next(input int n_req, input logic [TAG_IDW-1:0] idx);
    if (int'(idx) >= n_req - 1) return '0;
    return idx + TAG_IDW'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_add_sched_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick, first eligible at/after ptr |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && eligible[i] && (((int'(ptr) + k) % N_REQ) == i)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_add_sched.sv
// +--------------------------------------------------------------------------+
// | fp_add_sched : round-robin sharing of one pipelined FP32 adder           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fp_add_sched
  import fp_add_sched_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADD_LAT = DEF_ADD_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_op1,
  input  logic [FP_W*N_REQ-1:0] req_op2,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]       rsp_res,
  output logic [FP_W-1:0]       add_op_1,
  output logic [FP_W-1:0]       add_op_2,
  output logic                  add_en,
  input  logic [FP_W-1:0]       add_res,
  input  logic                  add_val,
  output logic                  busy,
  output logic                  err
);

  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int MASK_W = $clog2(ADD_LAT + 2);

  logic [IDW-1:0]             ptr_q, ptr_d;
  logic [N_REQ-1:0]           outstanding_q, outstanding_d;
  logic                       add_en_q, add_en_d;
  logic [FP_W-1:0]            add_op_1_q, add_op_1_d;
  logic [FP_W-1:0]            add_op_2_q, add_op_2_d;
  logic [IDW-1:0]             launch_id_q, launch_id_d;
  tag_t [ADD_LAT-1:0]         tag_q, tag_d;
  logic [N_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [FP_W-1:0]            rsp_res_q, rsp_res_d;
  logic                       err_q, err_d;
  logic [MASK_W-1:0]          mask_q, mask_d;

  logic [N_REQ-1:0]           eligible;
  logic [N_REQ-1:0]           grant;
  logic [IDW-1:0]             grant_idx;
  logic                       tag_any;
  tag_t                       tag_last;

  assign eligible = req_valid & ~outstanding_q;
  assign tag_last = tag_q[ADD_LAT-1];

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .eligible  (eligible),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    add_op_1_d  = add_op_1_q;
    add_op_2_d  = add_op_2_q;
    add_en_d    = |grant;
    launch_id_d = launch_id_q;
    ptr_d       = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        add_op_1_d = req_op1[i*FP_W +: FP_W];
        add_op_2_d = req_op2[i*FP_W +: FP_W];
      end
    end
    if (|grant) begin
      launch_id_d = grant_idx;
      ptr_d       = IDW'(rr_next(N_REQ, TAG_IDW'(grant_idx)));
    end

    // Free-running shift mirrors the adder's uncontrolled stage enables.
    tag_d    = tag_q;
    tag_d[0] = '{v: add_en_q, id: TAG_IDW'(launch_id_q)};
    for (int k = 1; k < ADD_LAT; k++) tag_d[k] = tag_q[k-1];

    tag_any = 1'b0;
    for (int k = 0; k < ADD_LAT; k++) tag_any = tag_any | tag_q[k].v;

    rsp_valid_d = '0;
    rsp_res_d   = rsp_res_q;
    if (tag_last.v) rsp_res_d = add_res;
    for (int i = 0; i < N_REQ; i++) begin
      if (tag_last.v && (tag_last.id == TAG_IDW'(i))) rsp_valid_d[i] = 1'b1;
    end

    // A requester frees up only after its response cycle, never the same cycle.
    outstanding_d = (outstanding_q & ~rsp_valid_q) | grant;

    mask_d = (mask_q != '0) ? mask_q - MASK_W'(1) : mask_q;
    err_d  = err_q | ((mask_q == '0) && (add_val != tag_last.v));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      outstanding_q <= '0;
      add_en_q      <= 1'b0;
      add_op_1_q    <= '0;
      add_op_2_q    <= '0;
      launch_id_q   <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_res_q     <= '0;
      err_q         <= 1'b0;
      mask_q        <= MASK_W'(ADD_LAT + 1);
    end else begin
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      add_en_q      <= add_en_d;
      add_op_1_q    <= add_op_1_d;
      add_op_2_q    <= add_op_2_d;
      launch_id_q   <= launch_id_d;
      tag_q         <= tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_res_q     <= rsp_res_d;
      err_q         <= err_d;
      mask_q        <= mask_d;
    end
  end

  assign req_ready = grant;
  assign add_en    = add_en_q;
  assign add_op_1  = add_op_1_q;
  assign add_op_2  = add_op_2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign err       = err_q;
  assign busy      = (|outstanding_q) | add_en_q | tag_any;

endmodule

`default_nettype wire
